register_bank: RTL and testbench

Parametrised successor to the single accumulator register: a bank of `NUM_REGS` general-purpose registers of `WIDTH` bits. It sits between the CPU's result bus (`CBus`) and the ALU operand buses (`ABus`, `BBus`). Each cycle it performs one addressed write operation (load, clear, increment or decrement). Two independent asynchronous read ports drive the operand buses, and a registered wrap flag reports increment/decrement overflow.

---
 rtl/register_bank_if.sv | 27 ++
 rtl/register_bank.sv | 75 +++++++
 tb/tb_register_bank.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/register_bank_if.sv
// Bus bundle between the CPU datapath and the register bank.
// It carries the result-bus write side, the two operand read ports and the status flags.
interface register_bank_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
);
    logic [WIDTH-1:0]  CBus;
    logic              Write;
    logic [ADDR_W-1:0] WriteAddr;
    logic [1:0]        WriteMode;
    logic [ADDR_W-1:0] ReadAddrA;
    logic [ADDR_W-1:0] ReadAddrB;
    logic [WIDTH-1:0]  ABus;
    logic [WIDTH-1:0]  BBus;
    logic              Wrap;
    logic              ZeroA;

    modport master (
        output CBus, Write, WriteAddr, WriteMode, ReadAddrA, ReadAddrB,
        input  ABus, BBus, Wrap, ZeroA
    );

    modport slave (
        input  CBus, Write, WriteAddr, WriteMode, ReadAddrA, ReadAddrB,
        output ABus, BBus, Wrap, ZeroA
    );
endinterface

// File: rtl/register_bank.sv
// General-purpose register bank: one addressed load/clear/inc/dec per cycle,
// two combinational read ports and a registered wrap flag.
module register_bank #(
    parameter int               WIDTH       = 8,
    parameter int               NUM_REGS    = 4,
    parameter int               ADDR_W      = $clog2(NUM_REGS),
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic            Clock,
    input logic            Reset,
    register_bank_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_LOAD  = 2'b00,
        MODE_CLEAR = 2'b01,
        MODE_INC   = 2'b10,
        MODE_DEC   = 2'b11
    } mode_e;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] a_bus;
    logic [WIDTH-1:0] b_bus;

    // Address decode by comparison, so unmatched addresses fall through untouched.
    always_comb begin
        regs_d = regs_q;
        wrap_d = wrap_q;
        if (bus.Write) begin
            wrap_d = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.WriteAddr == ADDR_W'(i)) begin
                    unique case (mode_e'(bus.WriteMode))
                        MODE_LOAD:  regs_d[i] = bus.CBus;
                        MODE_CLEAR: regs_d[i] = '0;
                        MODE_INC: begin
                            regs_d[i] = regs_q[i] + WIDTH'(1);
                            wrap_d    = &regs_q[i];
                        end
                        MODE_DEC: begin
                            regs_d[i] = regs_q[i] - WIDTH'(1);
                            wrap_d    = ~|regs_q[i];
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        a_bus = '0;
        b_bus = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.ReadAddrA == ADDR_W'(i)) a_bus = regs_q[i];
            if (bus.ReadAddrB == ADDR_W'(i)) b_bus = regs_q[i];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.ABus  = a_bus;
    assign bus.BBus  = b_bus;
    assign bus.Wrap  = wrap_q;
    assign bus.ZeroA = (a_bus == '0);
endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: an 8-bit/4-register and a 4-bit/3-register instance
// driven in lockstep and compared against an arithmetic reference model.
module tb_register_bank;
    logic Clock;
    logic Reset;

    register_bank_if #(.WIDTH(8), .ADDR_W(2)) bus8 ();
    register_bank_if #(.WIDTH(4), .ADDR_W(2)) bus4 ();

    register_bank #(.WIDTH(8), .NUM_REGS(4)) dut8 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus8.slave)
    );

    register_bank #(.WIDTH(4), .NUM_REGS(3)) dut4 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus4.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: index 0 is the 8-bit bank, index 1 the 4-bit bank.
    int mdl [2][4];
    int wrp [2];
    int wid [2] = '{8, 4};
    int nrg [2] = '{4, 3};
    int cur_ra;
    int cur_rb;
    bit pre_ok = 1'b0;

    function automatic int rd(input int d, input int a);
        return (a < nrg[d]) ? mdl[d][a] : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ph);
        check({ph, "/A8"}, 32'(bus8.ABus),  rd(0, cur_ra));
        check({ph, "/B8"}, 32'(bus8.BBus),  rd(0, cur_rb));
        check({ph, "/Z8"}, 32'(bus8.ZeroA), (rd(0, cur_ra) == 0) ? 1 : 0);
        check({ph, "/W8"}, 32'(bus8.Wrap),  wrp[0]);
        check({ph, "/A4"}, 32'(bus4.ABus),  rd(1, cur_ra));
        check({ph, "/B4"}, 32'(bus4.BBus),  rd(1, cur_rb));
        check({ph, "/Z4"}, 32'(bus4.ZeroA), (rd(1, cur_ra) == 0) ? 1 : 0);
        check({ph, "/W4"}, 32'(bus4.Wrap),  wrp[1]);
    endtask

    task automatic model_edge(input bit rst, input bit w, input int addr, input int mode,
                              input int data);
        for (int d = 0; d < 2; d++) begin
            int top;
            top = (1 << wid[d]) - 1;
            if (rst) begin
                for (int r = 0; r < 4; r++) mdl[d][r] = 0;
                wrp[d] = 0;
            end else if (w) begin
                wrp[d] = 0;
                if (addr < nrg[d]) begin
                    case (mode)
                        0: mdl[d][addr] = data & top;
                        1: mdl[d][addr] = 0;
                        2: begin
                            wrp[d] = (mdl[d][addr] == top) ? 1 : 0;
                            mdl[d][addr] = (mdl[d][addr] + 1) % (top + 1);
                        end
                        default: begin
                            wrp[d] = (mdl[d][addr] == 0) ? 1 : 0;
                            mdl[d][addr] = (mdl[d][addr] + top) % (top + 1);
                        end
                    endcase
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, check old state, take the edge, check new state.
    task automatic applyStimulus(input bit rst, input bit w, input int addr, input int mode,
                                 input int data, input int ra, input int rb);
        Reset          = rst;
        bus8.Write     = w;
        bus8.WriteAddr = 2'(addr);
        bus8.WriteMode = 2'(mode);
        bus8.CBus      = 8'(data);
        bus8.ReadAddrA = 2'(ra);
        bus8.ReadAddrB = 2'(rb);
        bus4.Write     = w;
        bus4.WriteAddr = 2'(addr);
        bus4.WriteMode = 2'(mode);
        bus4.CBus      = 4'(data);
        bus4.ReadAddrA = 2'(ra);
        bus4.ReadAddrB = 2'(rb);
        cur_ra = ra;
        cur_rb = rb;
        #1;
        if (pre_ok) check_outputs("pre");
        @(posedge Clock);
        model_edge(rst, w, addr, mode, data);
        #1;
        check_outputs("post");
        pre_ok = 1'b1;
        @(negedge Clock);
    endtask

    initial begin
        Reset = 1'b1;
        bus8.Write = 1'b0; bus8.WriteAddr = '0; bus8.WriteMode = '0; bus8.CBus = '0;
        bus8.ReadAddrA = '0; bus8.ReadAddrB = '0;
        bus4.Write = 1'b0; bus4.WriteAddr = '0; bus4.WriteMode = '0; bus4.CBus = '0;
        bus4.ReadAddrA = '0; bus4.ReadAddrB = '0;
        @(negedge Clock);

        // Reset wins over a simultaneous load of FF into R0.
        applyStimulus(1, 1, 0, 0, 8'hFF, 0, 0);
        check("rst_A8", 32'(bus8.ABus), 0);
        check("rst_Z8", 32'(bus8.ZeroA), 1);
        check("rst_W8", 32'(bus8.Wrap), 0);

        applyStimulus(0, 1, 1, 0, 8'h0F, 1, 2);
        applyStimulus(0, 1, 2, 0, 8'hF0, 1, 2);
        check("dual_A8", 32'(bus8.ABus), 8'h0F);
        check("dual_B8", 32'(bus8.BBus), 8'hF0);

        // Increment wrap on R3; the 3-register bank must ignore address 3.
        applyStimulus(0, 1, 3, 0, 8'hFF, 3, 0);
        check("oor_A4", 32'(bus4.ABus), 0);
        applyStimulus(0, 1, 3, 2, 0, 3, 0);
        check("incwrap_A8", 32'(bus8.ABus), 8'h00);
        check("incwrap_W8", 32'(bus8.Wrap), 1);
        check("incwrap_Z8", 32'(bus8.ZeroA), 1);
        check("oor_W4", 32'(bus4.Wrap), 0);
        applyStimulus(0, 1, 3, 2, 0, 3, 0);
        check("inc_A8", 32'(bus8.ABus), 8'h01);
        check("inc_W8", 32'(bus8.Wrap), 0);

        // Decrement wrap on R0, then hold.
        applyStimulus(0, 1, 0, 1, 0, 0, 3);
        applyStimulus(0, 1, 0, 3, 0, 0, 3);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 3, 0, 0, 3);
        check("hold_A8", 32'(bus8.ABus), 8'hFF);
        check("hold_W8", 32'(bus8.Wrap), 1);
        check("hold_A4", 32'(bus4.ABus), 4'hF);
        check("hold_W4", 32'(bus4.Wrap), 1);

        // Read-during-write: old value until the edge.
        applyStimulus(0, 1, 1, 0, 8'h55, 1, 2);
        applyStimulus(0, 0, 0, 0, 0, 1, 2);
        check("rdw_before_A8", 32'(bus8.ABus), 8'h55);
        applyStimulus(0, 1, 1, 0, 8'hAA, 1, 2);
        check("rdw_after_A8", 32'(bus8.ABus), 8'hAA);
        check("rdw_other_B8", 32'(bus8.BBus), 8'hF0);

        // Variant wrap: 4'hF incremented in R0 of the narrow bank.
        applyStimulus(0, 1, 0, 0, 8'h0F, 0, 1);
        applyStimulus(0, 1, 0, 2, 0, 0, 1);
        check("var_incwrap_A4", 32'(bus4.ABus), 0);
        check("var_incwrap_W4", 32'(bus4.Wrap), 1);

        // Mid-sequence reset, then the first write acts on the reset value.
        applyStimulus(1, 1, 2, 2, 0, 2, 1);
        applyStimulus(0, 1, 2, 3, 0, 2, 1);
        check("postrst_dec_A8", 32'(bus8.ABus), 8'hFF);
        check("postrst_dec_W8", 32'(bus8.Wrap), 1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
